// File: rtl/router_pkg.sv
// Shared definitions for the router packet FIFO: default widths and header layout.
package router_pkg;

    // Default payload width of a router word.
    localparam int DATA_W_DEF = 8;

    // The header length field occupies data[DATA_W-1:LEN_LSB]; the low bits carry the address.
    localparam int LEN_LSB = 2;

    // Width of the header length field for a given payload width.
    function automatic int len_w(input int dw);
        return dw - LEN_LSB;
    endfunction

    // Index of the header tag bit in a stored {tag,data} word.
    function automatic int tag_idx(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage for the packet FIFO: synchronous write, combinational read.
// Kept in its own module so it can be replaced by a vendor macro.
module router_fifo_mem #(
    parameter int WORD_W = 9,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // Store the incoming word; contents are never reset.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO for one router destination port. Each word is stored with a
// header tag; the read side tracks packet length from the header and qualifies the
// registered output with SOP/EOP. Occupancy and almost flags are provided.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int LFD_DLY  = 1
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     lfd_state,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     read_enb,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     sop_out,
    output logic                     eop_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = len_w(DATA_W);
    localparam int CW = LW + 1;
    localparam int TB = tag_idx(DATA_W);

    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW-1:0]     r_fill;
    logic [CW-1:0]     r_cnt;
    logic              r_lfd_dly;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid;
    logic              r_sop;
    logic              r_eop;
    logic              r_ovf;

    logic              w_empty;
    logic              w_full;
    logic              w_tag;
    logic              w_wr;
    logic              w_rd;
    logic [DATA_W:0]   w_wr_word;
    logic [DATA_W:0]   w_rd_word;
    logic              w_rd_tag;
    logic [LW-1:0]     w_rd_len;

    // Same address with opposite wrap bits means the write pointer is a full lap ahead.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

    // With LFD_DLY the FSM raises lfd_state the cycle before it presents the header.
    assign w_tag     = (LFD_DLY != 0) ? r_lfd_dly : lfd_state;
    assign w_wr      = write_enb & ~w_full & ~soft_reset;
    assign w_rd      = read_enb & ~w_empty & ~soft_reset;
    assign w_wr_word = {w_tag, data_in};

    assign w_rd_tag = w_rd_word[TB];
    assign w_rd_len = w_rd_word[DATA_W-1:LEN_LSB];

    router_fifo_mem #(
        .WORD_W (DATA_W + 1),
        .ADDR_W (AW)
    ) u_mem (
        .clock     (clock),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wptr[AW-1:0]),
        .i_wr_data (w_wr_word),
        .i_rd_addr (r_rptr[AW-1:0]),
        .o_rd_data (w_rd_word)
    );

    // Delay the header marker by one cycle so it lines up with the header word.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lfd_dly <= 1'b0;
        end else if (soft_reset) begin
            r_lfd_dly <= 1'b0;
        end else begin
            r_lfd_dly <= lfd_state;
        end
    end

    // Write pointer advance and sticky overflow on a write attempt while full.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_ovf  <= 1'b0;
        end else if (soft_reset) begin
            r_wptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (write_enb && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Read pointer advance on an accepted pop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rptr <= '0;
        end else if (soft_reset) begin
            r_rptr <= '0;
        end else if (w_rd) begin
            r_rptr <= r_rptr + PW'(1);
        end
    end

    // Occupancy: a simultaneous accepted write and pop leaves it unchanged.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fill <= '0;
        end else if (soft_reset) begin
            r_fill <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_fill <= r_fill + PW'(1);
                2'b01:   r_fill <= r_fill - PW'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Registered read port with packet tracking: a header reloads the count (even
    // mid-packet), untagged words count down and the 1->0 step marks the parity word.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_cnt      <= '0;
        end else if (soft_reset) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_cnt      <= '0;
        end else if (w_rd) begin
            r_data_out <= w_rd_word[DATA_W-1:0];
            r_valid    <= 1'b1;
            if (w_rd_tag) begin
                r_cnt <= {1'b0, w_rd_len} + CW'(1);
                r_sop <= 1'b1;
                r_eop <= 1'b0;
            end else begin
                r_sop <= 1'b0;
                r_eop <= (r_cnt == CW'(1));
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end else begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
        end
    end

    assign data_out     = r_data_out;
    assign data_valid   = r_valid;
    assign sop_out      = r_sop;
    assign eop_out      = r_eop;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_fill >= PW'(AF_LEVEL));
    assign almost_empty = (r_fill <= PW'(AE_LEVEL));
    assign fill_level   = r_fill;
    assign overflow_err = r_ovf;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: packet framing, full/overflow, wrap,
// concurrent traffic, soft and asynchronous reset.
module tb_router_pkt_fifo;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sop_out;
    logic       eop_out;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] fill_level;
    logic       overflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];

    router_pkt_fifo #(
        .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .LFD_DLY(1)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .soft_reset   (soft_reset),
        .write_enb    (write_enb),
        .lfd_state    (lfd_state),
        .data_in      (data_in),
        .read_enb     (read_enb),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .sop_out      (sop_out),
        .eop_out      (eop_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill_level   (fill_level),
        .overflow_err (overflow_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d, input logic hdr);
        if (hdr) begin
            lfd_state = 1'b1;
            write_enb = 1'b0;
            step();
        end
        lfd_state = 1'b0;
        write_enb = 1'b1;
        data_in   = d;
        step();
        write_enb = 1'b0;
        $display("[TB] wr 0x%02h hdr=%0d fill=%0d", d, hdr, fill_level);
    endtask

    task automatic read_word(input string tag, input logic [7:0] d, input logic sop, input logic eop);
        read_enb = 1'b1;
        step();
        read_enb = 1'b0;
        $display("[TB] rd %s 0x%02h sop=%0d eop=%0d", tag, data_out, sop_out, eop_out);
        chk({tag, ".valid"}, data_valid, 1);
        chk({tag, ".data"},  data_out, d);
        chk({tag, ".sop"},   sop_out, sop);
        chk({tag, ".eop"},   eop_out, eop);
    endtask

    initial begin
        resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
        data_in = '0; read_enb = 1'b0;
        step(); step();
        resetn = 1'b1;
        step();

        // 1. Reset state
        chk("rst.empty", empty, 1);
        chk("rst.full", full, 0);
        chk("rst.fill", fill_level, 0);
        chk("rst.dout", data_out, 0);
        chk("rst.valid", data_valid, 0);
        chk("rst.ae", almost_empty, 1);
        chk("rst.ovf", overflow_err, 0);

        // 2. One packet, len 5: header, 5 payload, parity
        write_word(8'h14, 1'b1);
        for (int i = 1; i <= 5; i++) write_word(8'(i), 1'b0);
        write_word(8'hAB, 1'b0);
        chk("pkt.fill", fill_level, 7);
        chk("pkt.ae", almost_empty, 0);
        read_word("pkt.w1", 8'h14, 1, 0);
        for (int i = 1; i <= 5; i++) read_word("pkt.pl", 8'(i), 0, 0);
        read_word("pkt.w7", 8'hAB, 0, 1);
        chk("pkt.empty", empty, 1);
        read_enb = 1'b1;
        step();
        read_enb = 1'b0;
        chk("pkt.rd_empty.valid", data_valid, 0);
        chk("pkt.rd_empty.dout", data_out, 0);
        chk("pkt.rd_empty.fill", fill_level, 0);

        // 3. Fill to full, overflow, drain
        for (int i = 0; i < 16; i++) begin
            write_word(8'h30 + 8'(i), 1'b0);
            if (i == 12) chk("fill13.af", almost_full, 0);
            if (i == 13) chk("fill14.af", almost_full, 1);
            if (i == 14) chk("fill15.full", full, 0);
        end
        chk("fill16.full", full, 1);
        chk("fill16.fill", fill_level, 16);
        chk("fill16.ovf", overflow_err, 0);
        write_word(8'hEE, 1'b0);
        chk("ovf.fill", fill_level, 16);
        chk("ovf.err", overflow_err, 1);
        for (int i = 0; i < 16; i++) read_word("drain", 8'h30 + 8'(i), 0, 0);
        chk("drain.empty", empty, 1);
        chk("drain.ovf_sticky", overflow_err, 1);
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        chk("srst.ovf", overflow_err, 0);

        // 4. Wrap: three rounds of 10 words
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) write_word(8'(r * 16 + i + 8'h40), 1'b0);
            chk("wrap.fill", fill_level, 10);
            chk("wrap.full", full, 0);
            chk("wrap.empty", empty, 0);
            for (int i = 0; i < 10; i++) read_word("wrap", 8'(r * 16 + i + 8'h40), 0, 0);
            chk("wrap.empty_end", empty, 1);
        end

        // 5. Concurrent read+write at fill 8
        for (int i = 0; i < 8; i++) begin
            write_word(8'h80 + 8'(i), 1'b0);
            exp_q.push_back(8'h80 + 8'(i));
        end
        for (int i = 0; i < 20; i++) begin
            logic [7:0] e;
            write_enb = 1'b1;
            read_enb  = 1'b1;
            data_in   = 8'hC0 + 8'(i);
            exp_q.push_back(data_in);
            e = exp_q.pop_front();
            step();
            write_enb = 1'b0;
            read_enb  = 1'b0;
            $display("[TB] rw 0x%02h fill=%0d", data_out, fill_level);
            chk("rw.fill", fill_level, 8);
            chk("rw.valid", data_valid, 1);
            chk("rw.data", data_out, e);
        end
        while (exp_q.size() > 0) read_word("rw.drain", exp_q.pop_front(), 0, 0);
        chk("rw.empty", empty, 1);

        // 6a. soft_reset mid-packet with read_enb held
        write_word(8'h14, 1'b1);
        for (int i = 1; i <= 5; i++) write_word(8'h10 + 8'(i), 1'b0);
        write_word(8'hAB, 1'b0);
        read_word("sr.w1", 8'h14, 1, 0);
        read_word("sr.w2", 8'h11, 0, 0);
        read_word("sr.w3", 8'h12, 0, 0);
        read_enb   = 1'b1;
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        read_enb   = 1'b0;
        chk("sr.empty", empty, 1);
        chk("sr.valid", data_valid, 0);
        chk("sr.fill", fill_level, 0);
        chk("sr.dout", data_out, 0);
        write_word(8'h03, 1'b1);
        write_word(8'h5A, 1'b0);
        read_word("sr.hdr0", 8'h03, 1, 0);
        read_word("sr.par0", 8'h5A, 0, 1);

        // 6b. asynchronous resetn pulse mid-write
        write_word(8'h21, 1'b0);
        write_word(8'h22, 1'b0);
        write_word(8'h23, 1'b0);
        read_word("ar.pre", 8'h21, 0, 0);
        write_enb = 1'b1;
        data_in   = 8'h24;
        #2;
        resetn = 1'b0;
        #1;
        chk("ar.empty", empty, 1);
        chk("ar.fill", fill_level, 0);
        chk("ar.valid", data_valid, 0);
        chk("ar.full", full, 0);
        step();
        write_enb = 1'b0;
        resetn    = 1'b1;
        step();
        chk("ar.fill_hold", fill_level, 0);
        write_word(8'h08, 1'b1);
        write_word(8'h61, 1'b0);
        write_word(8'h62, 1'b0);
        write_word(8'h63, 1'b0);
        read_word("ar.hdr", 8'h08, 1, 0);
        read_word("ar.p1", 8'h61, 0, 0);
        read_word("ar.p2", 8'h62, 0, 0);
        read_word("ar.par", 8'h63, 0, 1);
        chk("ar.empty_end", empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
